// File: rtl/arb8_rr.sv
// arb8_rr: 8-way round-robin arbiter driving the select of a shared 8:1 mux.
// Grants one requester at a time and holds the grant until the owner
// releases its request. A released grant passes straight to the next
// pending requester without a dead cycle.
//
// Optional feature macro: ARB8_HOLD_LIMIT_EN
//   When defined, an owner is preempted after MAX_HOLD consecutive grant
//   cycles if any other requester is waiting.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   req    in   [7:0] level-sensitive request vector
//   gnt    out  [7:0] registered one-hot grant, zero when idle
//   sel    out  [2:0] registered index of current/last owner (mux select)
//   busy   out  registered, high whenever gnt is nonzero
module arb8_rr #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       busy
);

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
    $error("arb8_rr: MAX_HOLD must be in 2..256");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [N_REQ-1:0]   r_gnt;
  logic [N_REQ-1:0]   w_gnt_nxt;
  logic [IDX_W-1:0]   r_sel;
  logic [IDX_W-1:0]   w_sel_nxt;
  logic               r_busy;
  logic               w_busy_nxt;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   w_ptr_nxt;

  logic [N_REQ-1:0]   w_elig;
  logic [IDX_W:0]     w_pick;
  logic               w_found;
  logic [IDX_W-1:0]   w_win;
  logic               w_release;
  logic               w_preempt;
  logic               w_new_grant;
  logic               w_go_idle;

  // First set bit of v searching from p upward with wrap; returns {found, idx}.
  function automatic logic [IDX_W:0] pick(input logic [N_REQ-1:0] v,
                                          input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] idx;
    logic [IDX_W:0]   res;
    res = '0;
    // Walk from the lowest-priority slot down so the highest-priority hit wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = p + IDX_W'(k);
      if (v[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

`ifdef ARB8_HOLD_LIMIT_EN
  localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

  // Number of grant cycles the current owner has had, including the present one.
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_preempt = (r_state == S_OWN) && (r_cnt >= CNT_W'(MAX_HOLD)) &&
                     ((req & ~(N_REQ'(1) << r_sel)) != '0);

  // Hold counter: load on new grant, saturate while holding, clear when idle.
  always_comb begin
    w_cnt_nxt = '0;
    if (w_new_grant) begin
      w_cnt_nxt = CNT_W'(1);
    end else if (r_state == S_OWN && !w_go_idle) begin
      w_cnt_nxt = (r_cnt >= CNT_W'(MAX_HOLD)) ? CNT_W'(MAX_HOLD) : r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= w_cnt_nxt;
  end
`else
  assign w_preempt = 1'b0;
`endif

  // Owner bit is masked in OWN so a preempted owner cannot win its own slot back.
  assign w_elig    = (r_state == S_OWN) ? (req & ~(N_REQ'(1) << r_sel)) : req;
  assign w_pick    = pick(w_elig, r_ptr);
  assign w_found   = w_pick[IDX_W];
  assign w_win     = w_pick[IDX_W-1:0];
  assign w_release = !req[r_sel] || w_preempt;

  assign w_new_grant = w_found && ((r_state == S_IDLE) || w_release);
  assign w_go_idle   = (r_state == S_OWN) && w_release && !w_found;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_busy  <= 1'b0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_busy  <= w_busy_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    if (w_new_grant)    w_state_nxt = S_OWN;
    else if (w_go_idle) w_state_nxt = S_IDLE;
  end

  // Next values of the registered outputs and the rotation pointer.
  always_comb begin
    w_gnt_nxt  = r_gnt;
    w_sel_nxt  = r_sel;
    w_busy_nxt = r_busy;
    w_ptr_nxt  = r_ptr;
    if (w_new_grant) begin
      w_gnt_nxt  = N_REQ'(1) << w_win;
      w_sel_nxt  = w_win;
      w_busy_nxt = 1'b1;
      w_ptr_nxt  = w_win + IDX_W'(1);
    end else if (w_go_idle) begin
      // sel keeps the last owner so the mux output stays put while idle.
      w_gnt_nxt  = '0;
      w_busy_nxt = 1'b0;
    end
  end

  assign gnt  = r_gnt;
  assign sel  = r_sel;
  assign busy = r_busy;

endmodule

// File: tb/tb_arb8_rr.sv
// Directed testbench for arb8_rr: reset, grant/release latency, round-robin
// fairness with wrap, pointer behaviour and owner hold, plus a per-cycle
// invariant monitor on gnt/sel/busy.
module tb_arb8_rr;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_gnt;
  logic       prev_valid = 1'b0;
  logic [2:0] prev_sel   = '0;
  logic       prev_busy  = 1'b0;

  arb8_rr #(.MAX_HOLD(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt),
    .sel   (sel),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Invariants sampled on the falling edge, away from the active edge.
  always @(negedge rst_n) prev_valid = 1'b0;

  always @(negedge clk) begin
    chk("inv_onehot0", 8'($onehot0(gnt)), 8'd1);
    chk("inv_busy_or", 8'(busy), 8'(|gnt));
    chk("inv_gnt_sel", 8'(gnt[sel]), 8'(busy));
    if (rst_n && prev_valid && !prev_busy && !busy)
      chk("inv_sel_stable", 8'(sel), 8'(prev_sel));
    prev_sel   = sel;
    prev_busy  = busy;
    prev_valid = rst_n;
  end

  initial begin
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, 8'h00);
    chk("rst_sel", 8'(sel), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_noreq_gnt", gnt, 8'h00);

    // Single request from idle, then release.
    req = 8'h08;
    #1;
    chk("single_pre_edge_gnt", gnt, 8'h00);
    tick();
    chk("single_gnt", gnt, 8'h08);
    chk("single_sel", 8'(sel), 8'd3);
    chk("single_busy", 8'(busy), 8'd1);
    req = 8'h00;
    tick();
    chk("single_rel_gnt", gnt, 8'h00);
    chk("single_rel_sel", 8'(sel), 8'd3);
    chk("single_rel_busy", 8'(busy), 8'd0);
    tick();
    chk("idle_sel_hold", 8'(sel), 8'd3);

    // Reset while owner 5 holds the grant.
    req = 8'h20;
    tick();
    chk("pre_rst_gnt", gnt, 8'h20);
    chk("pre_rst_sel", 8'(sel), 8'd5);
    rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", gnt, 8'h00);
    chk("async_rst_sel", 8'(sel), 8'd0);
    chk("async_rst_busy", 8'(busy), 8'd0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("post_rst_gnt", gnt, 8'h20);
    chk("post_rst_sel", 8'(sel), 8'd5);
    req = 8'h00;
    tick();
    chk("post_rst_rel_gnt", gnt, 8'h00);
    chk("post_rst_rel_sel", 8'(sel), 8'd5);

    // Return pointer to 0, then full fairness rotation with one-cycle owners.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req = 8'hFF;
    tick();
    chk("rr_first_gnt", gnt, 8'h01);
    chk("rr_first_sel", 8'(sel), 8'd0);
    exp_gnt = 8'h01;
    for (int i = 1; i <= 8; i++) begin
      req = 8'hFF & ~exp_gnt;
      tick();
      exp_gnt = 8'(1) << (i % 8);
      chk("rr_gnt", gnt, exp_gnt);
      chk("rr_sel", 8'(sel), 8'(i % 8));
      chk("rr_busy", 8'(busy), 8'd1);
    end
    req = 8'h00;
    tick();
    chk("rr_end_gnt", gnt, 8'h00);
    chk("rr_end_sel", 8'(sel), 8'd0);

    // Wrap: owner 6 releases into req 0x05, search starts at 7.
    req = 8'h40;
    tick();
    chk("wrap_own6_gnt", gnt, 8'h40);
    req = 8'h05;
    tick();
    chk("wrap_gnt0", gnt, 8'h01);
    chk("wrap_sel0", 8'(sel), 8'd0);
    req = 8'h04;
    tick();
    chk("wrap_gnt2", gnt, 8'h04);
    chk("wrap_sel2", 8'(sel), 8'd2);
    req = 8'h00;
    tick();
    chk("wrap_idle_gnt", gnt, 8'h00);

    // Hold: owner 1 keeps its request for 20 cycles while requester 4 waits.
    req = 8'h02;
    tick();
    chk("hold_c1_gnt", gnt, 8'h02);
    req = 8'h12;
    for (int c = 2; c <= 20; c++) begin
      tick();
`ifdef ARB8_HOLD_LIMIT_EN
      exp_gnt = (c <= 16) ? 8'h02 : 8'h10;
`else
      exp_gnt = 8'h02;
`endif
      chk("hold_gnt", gnt, exp_gnt);
    end
    req = 8'h10;
    tick();
    chk("hold_next_gnt", gnt, 8'h10);
    chk("hold_next_sel", 8'(sel), 8'd4);
    req = 8'h00;
    tick();
    chk("hold_idle_gnt", gnt, 8'h00);
    chk("hold_idle_sel", 8'(sel), 8'd4);
    chk("hold_idle_busy", 8'(busy), 8'd0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
